// File: rtl/pixel_config_pkg.sv
// Shared states, default widths and accumulator sizing
// for the pixel-config packer.
package pixel_config_pkg;

  localparam int IN_W_DEF  = 32;
  localparam int OUT_W_DEF = 15;
  localparam int PIX_W_DEF = 16;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_CHECK = 6'b000010,
    S_READ  = 6'b000100,
    S_LOAD  = 6'b001000,
    S_EMIT  = 6'b010000,
    S_DONE  = 6'b100000
  } state_t;

  function automatic int acc_width(input int iw, input int ow);
    return iw + ow - 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pixel_config_packer_if.sv
// FIFO-side bundle of the packer: input FIFO read port
// and pixel-config FIFO write port.
interface pixel_config_packer_if
  import pixel_config_pkg::*;
#(
  parameter int IN_WIDTH  = IN_W_DEF,
  parameter int OUT_WIDTH = OUT_W_DEF
);
  logic [IN_WIDTH-1:0]  din;
  logic                 in_empty;
  logic                 in_rd_en;
  logic [OUT_WIDTH-1:0] dout;
  logic                 out_full;
  logic                 out_wr_en;

  modport master (
    input  din, in_empty, out_full,
    output in_rd_en, dout, out_wr_en
  );

  modport slave (
    output din, in_empty, out_full,
    input  in_rd_en, dout, out_wr_en
  );
endinterface

// File: rtl/pixel_config_gearbox.sv
// Bit accumulator: appends input words LSB-first and
// peels off output words from the bottom.
module pixel_config_gearbox
  import pixel_config_pkg::*;
#(
  parameter int IN_WIDTH  = IN_W_DEF,
  parameter int OUT_WIDTH = OUT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 emit,
  input  logic                 clr,
  input  logic [IN_WIDTH-1:0]  din,
  output logic [OUT_WIDTH-1:0] word,
  output logic                 have_word
);
  localparam int ACC_W = acc_width(IN_WIDTH, OUT_WIDTH);
  localparam int NB_W  = cnt_width(ACC_W);

  logic [ACC_W-1:0] acc;
  logic [NB_W-1:0]  nbits;

  // Append on load, consume on emit, drop residue on clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      nbits <= '0;
    end else if (clr) begin
      acc   <= '0;
      nbits <= '0;
    end else if (load) begin
      acc   <= acc | (ACC_W'(din) << nbits);
      nbits <= nbits + NB_W'(IN_WIDTH);
    end else if (emit) begin
      acc   <= acc >> OUT_WIDTH;
      nbits <= nbits - NB_W'(OUT_WIDTH);
    end
  end

  assign word      = acc[OUT_WIDTH-1:0];
  assign have_word = nbits >= NB_W'(OUT_WIDTH);

endmodule

// File: rtl/pixel_config_packer.sv
// Re-slices the control FIFO bitstream into pixel words.
// Optional WORD_CNT output: define PIXEL_PACKER_WORDCNT_EN.
module pixel_config_packer
  import pixel_config_pkg::*;
#(
  parameter int IN_WIDTH      = IN_W_DEF,
  parameter int OUT_WIDTH     = OUT_W_DEF,
  parameter int PIX_CNT_WIDTH = PIX_W_DEF
) (
  input  logic                     clk_in,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [PIX_CNT_WIDTH-1:0] n_pixel,
  pixel_config_packer_if.master    bus,
  output logic                     busy,
  output logic                     done
`ifdef PIXEL_PACKER_WORDCNT_EN
  ,
  output logic [PIX_CNT_WIDTH-1:0] word_cnt
`endif
);

  state_t                   state, nxt;
  logic [PIX_CNT_WIDTH-1:0] remaining;
  logic                     load, emit, clr, latch;
  logic [OUT_WIDTH-1:0]     word;
  logic                     have_word;

  pixel_config_gearbox #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_gearbox (
    .clk       (clk_in),
    .rst_n     (reset_n),
    .load      (load),
    .emit      (emit),
    .clr       (clr),
    .din       (bus.din),
    .word      (word),
    .have_word (have_word)
  );

  // Next-state and datapath controls; abort wins
  always_comb begin
    nxt   = state;
    load  = 1'b0;
    emit  = 1'b0;
    clr   = 1'b0;
    latch = 1'b0;
    if (abort) begin
      nxt = S_IDLE;
      clr = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          if (n_pixel != '0) begin
            latch = 1'b1;
            nxt   = S_CHECK;
          end else begin
            nxt = S_DONE;
          end
        end
        S_CHECK: begin
          if (remaining == '0)   nxt = S_DONE;
          else if (have_word)    nxt = S_EMIT;
          else if (!bus.in_empty) nxt = S_READ;
        end
        S_READ: nxt = S_LOAD;
        S_LOAD: begin
          load = 1'b1;
          nxt  = S_CHECK;
        end
        S_EMIT: if (!bus.out_full) begin
          emit = 1'b1;
          nxt  = S_CHECK;
        end
        S_DONE: begin
          clr = 1'b1;
          nxt = S_IDLE;
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  // State register and pixel countdown
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      remaining <= '0;
    end else begin
      state <= nxt;
      if (latch)
        remaining <= n_pixel;
      else if (emit)
        remaining <= remaining - PIX_CNT_WIDTH'(1);
    end
  end

  // Registered strobes and status derived from next state
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.in_rd_en  <= 1'b0;
      bus.out_wr_en <= 1'b0;
      bus.dout      <= '0;
    end else begin
      busy          <= nxt != S_IDLE;
      done          <= nxt == S_DONE;
      bus.in_rd_en  <= nxt == S_READ;
      bus.out_wr_en <= emit;
      if (emit)
        bus.dout <= word;
    end
  end

`ifdef PIXEL_PACKER_WORDCNT_EN
  // Saturating lifetime count of words written
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)
      word_cnt <= '0;
    else if (emit && word_cnt != '1)
      word_cnt <= word_cnt + PIX_CNT_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_pixel_config_packer.sv
// Scoreboard bench for pixel_config_packer: a bit-queue
// model predicts words, a monitor checks every write.
module tb_pixel_config_packer;
  import pixel_config_pkg::*;

  localparam int IW = 32;
  localparam int OW = 15;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] n_pixel = '0;
  logic          busy, done;
`ifdef PIXEL_PACKER_WORDCNT_EN
  logic [PW-1:0] word_cnt;
`endif

  pixel_config_packer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus();

  pixel_config_packer #(
    .IN_WIDTH      (IW),
    .OUT_WIDTH     (OW),
    .PIX_CNT_WIDTH (PW)
  ) dut (
    .clk_in   (clk),
    .reset_n  (rst_n),
    .start    (start),
    .abort    (abort),
    .n_pixel  (n_pixel),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
`ifdef PIXEL_PACKER_WORDCNT_EN
    ,
    .word_cnt (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int wbase = 0;
  int underflow = 0;
  logic rand_bp = 1'b0;
  logic starve = 1'b0;

  logic [OW-1:0] exp_q[$];
  logic [IW-1:0] sw[$];

  // Input FIFO model: standard (non-FWFT) read latency
  logic [IW-1:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.in_empty = starve || (rd_ptr == wr_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= wr_ptr;
      bus.din <= '0;
    end else if (bus.in_rd_en) begin
      if (rd_ptr != wr_ptr) begin
        bus.din <= mem[rd_ptr[11:0]];
        rd_ptr  <= rd_ptr + 1;
      end else begin
        underflow <= underflow + 1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write
  initial begin
    logic [OW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (bus.in_rd_en) rd_cnt++;
        if (done) done_cnt++;
        if (bus.out_wr_en) begin
          wr_cnt++;
          chk("wr_while_full", int'(bus.out_full), 0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %0h expected none",
                     bus.dout);
          end else begin
            e = exp_q.pop_front();
            chk("dout", int'(bus.dout), int'(e));
          end
        end
      end
    end
  end

  function automatic int nwords(input int n);
    return (n * OW + IW - 1) / IW;
  endfunction

  task automatic fill_random(input int n);
    sw.delete();
    for (int k = 0; k < nwords(n); k++)
      sw.push_back($urandom());
  endtask

  // Queue words into the FIFO, predict output, pulse START
  task automatic issue(input int n, input bit model);
    bit bq[$];
    logic [OW-1:0] v;
    foreach (sw[i]) begin
      mem[wr_ptr[11:0]] = sw[i];
      wr_ptr++;
      for (int b = 0; b < IW; b++) bq.push_back(sw[i][b]);
    end
    if (model) begin
      for (int i = 0; i < n; i++) begin
        v = '0;
        for (int b = 0; b < OW; b++) v[b] = bq.pop_front();
        exp_q.push_back(v);
      end
    end
    @(negedge clk);
    n_pixel = PW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int d0);
    for (int k = 0; k < 400 && done_cnt == d0; k++) begin
      @(negedge clk);
      if (rand_bp) bus.out_full = ($urandom_range(0, 3) == 0);
    end
    bus.out_full = 1'b0;
    chk({nm, "_done_seen"}, int'(done_cnt != d0), 1);
  endtask

  task automatic run(input string nm, input int n);
    int r0, w0, d0;
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
    issue(n, 1'b1);
    wait_done(nm, d0);
    repeat (2) @(negedge clk);
    chk({nm, "_reads"}, rd_cnt - r0, sw.size());
    chk({nm, "_writes"}, wr_cnt - w0, n);
    chk({nm, "_pending"}, exp_q.size(), 0);
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r0, w0, d0;
    logic [OW-1:0] held;
    bus.out_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(bus.in_rd_en), 0);
    chk("rst_wr_en", int'(bus.out_wr_en), 0);
    chk("rst_dout", int'(bus.dout), 0);
    rst_n = 1'b1;
    @(negedge clk);

    sw.delete();
    sw.push_back(32'hFFFF_FFFF);
    sw.push_back(32'h0000_0000);
    run("pack", 4);

    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
    n_pixel = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 1);
    @(negedge clk);
    chk("zero_done_low", int'(done), 0);
    chk("zero_busy_low", int'(busy), 0);
    chk("zero_rw", (rd_cnt - r0) + (wr_cnt - w0), 0);
    chk("zero_pulses", done_cnt - d0, 1);

    fill_random(3);
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
    issue(3, 1'b1);
    for (int k = 0; k < 60 && wr_cnt == w0; k++) @(negedge clk);
    chk("bp_first", wr_cnt - w0, 1);
    bus.out_full = 1'b1;
    held = bus.dout;
    repeat (10) begin
      @(negedge clk);
      chk("bp_wr_en", int'(bus.out_wr_en), 0);
      chk("bp_dout", int'(bus.dout), int'(held));
    end
    bus.out_full = 1'b0;
    wait_done("bp", d0);
    chk("bp_writes", wr_cnt - w0, 3);
    chk("bp_reads", rd_cnt - r0, 2);
    chk("bp_pending", exp_q.size(), 0);

    fill_random(2);
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
    starve = 1'b1;
    issue(2, 1'b1);
    repeat (10) @(negedge clk);
    chk("starve_reads", rd_cnt - r0, 0);
    chk("starve_busy", int'(busy), 1);
    starve = 1'b0;
    wait_done("starve", d0);
    repeat (2) @(negedge clk);
    chk("starve_reads2", rd_cnt - r0, 1);
    chk("starve_writes", wr_cnt - w0, 2);

    sw.delete();
    sw.push_back(32'h1234_5678);
    run("discard_a", 1);
    sw.delete();
    sw.push_back(32'h0000_0000);
    run("discard_b", 1);

    rand_bp = 1'b1;
    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(1, 12);
      fill_random(n);
      run("rand", n);
    end
    rand_bp = 1'b0;

    sw.delete();
    sw.push_back($urandom());
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
    bus.out_full = 1'b1;
    issue(8, 1'b0);
    repeat (12) @(negedge clk);
    chk("abort_reads", rd_cnt - r0, 1);
    chk("abort_busy_pre", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    bus.out_full = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_write", wr_cnt - w0, 0);
    fill_random(3);
    run("post_abort", 3);

    fill_random(10);
    w0 = wr_cnt;
    issue(10, 1'b1);
    for (int k = 0; k < 100 && wr_cnt - w0 < 3; k++) @(negedge clk);
    chk("mid_writes", int'(wr_cnt - w0 >= 3), 1);
`ifdef PIXEL_PACKER_WORDCNT_EN
    chk("word_cnt", int'(word_cnt), wr_cnt - wbase);
`endif
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_rd_en", int'(bus.in_rd_en), 0);
    chk("mid_rst_wr_en", int'(bus.out_wr_en), 0);
    chk("mid_rst_dout", int'(bus.dout), 0);
`ifdef PIXEL_PACKER_WORDCNT_EN
    chk("mid_rst_word_cnt", int'(word_cnt), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wbase = wr_cnt;
    fill_random(5);
    run("post_reset", 5);
`ifdef PIXEL_PACKER_WORDCNT_EN
    chk("word_cnt_final", int'(word_cnt), wr_cnt - wbase);
`endif
    chk("underflow", underflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
